// File: rtl/pe_edge_sequencer_pkg.sv
// rtl/pe_edge_sequencer_pkg.sv - shared PE edge-sequencer types and default geometry
package pe_edge_sequencer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pe_state_t;

   localparam int PE_W_GROUP  = 4;
   localparam int PE_O_GROUP  = 4;
   localparam int PE_I_SPAN   = PE_W_GROUP + PE_O_GROUP - 1;
   localparam int PE_I_STRIDE = PE_O_GROUP - 1;
   localparam int PE_I_BLOCKS = 4;
   localparam int PE_W_AW     = 2;
   localparam int PE_O_AW     = 2;
   localparam int PE_I_AW     = 4;
   localparam int PE_BC_W     = 2;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int pe_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_wrap_counter.sv
// rtl/pe_wrap_counter.sv - enabled up-counter wrapping to zero after LIMIT-1
module pe_wrap_counter
   import pe_edge_sequencer_pkg::*;
#(
   parameter int WIDTH = PE_W_AW,
   parameter int LIMIT = PE_W_GROUP
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             sclr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT - 1);

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         count <= '0;
      end else if (sclr) begin
         count <= '0;
      end else if (en) begin
         count <= (count == MAX) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/pe_edge_sequencer.sv
// rtl/pe_edge_sequencer.sv - address sequencer for the weight, input and output edges of a PE array
module pe_edge_sequencer
   import pe_edge_sequencer_pkg::*;
#(
   parameter int W_GROUP  = PE_W_GROUP,
   parameter int O_GROUP  = PE_O_GROUP,
   parameter int I_SPAN   = PE_I_SPAN,
   parameter int I_STRIDE = PE_I_STRIDE,
   parameter int I_BLOCKS = PE_I_BLOCKS,
   parameter int W_AW     = PE_W_AW,
   parameter int O_AW     = PE_O_AW,
   parameter int I_AW     = PE_I_AW,
   parameter int BC_W     = PE_BC_W
) (
   input  logic            clk,
   input  logic            aclr,
   input  logic            sclr,
   input  logic            start,
   input  logic            en_w,
   input  logic            en_i,
   input  logic            en_o_in,
   input  logic            en_o_out,
   output logic [W_AW-1:0] w_addr,
   output logic [O_AW-1:0] o_in_addr,
   output logic [O_AW-1:0] o_out_addr,
   output logic [I_AW-1:0] i_addr,
   output logic [BC_W-1:0] i_block,
   output logic            busy,
   output logic            done,
   output logic            err_en
);

   localparam int OFF_W = pe_cnt_w(I_SPAN);

   pe_state_t        state;
   logic             run;
   logic [OFF_W-1:0] offset;
   logic             off_max;
   logic             blk_max;
   logic             pass_end;
   logic             edge_clr;
   logic             any_en;

   // Enables only move counters while a pass is running; IDLE beats are flagged instead.
   assign run      = (state == RUN);
   assign off_max  = (offset == OFF_W'(I_SPAN - 1));
   assign blk_max  = (i_block == BC_W'(I_BLOCKS - 1));
   assign pass_end = run & en_i & off_max & blk_max;
   assign edge_clr = sclr | pass_end;
   assign any_en   = en_w | en_i | en_o_in | en_o_out;

   pe_wrap_counter #(.WIDTH(W_AW), .LIMIT(W_GROUP)) u_w_cnt (
      .clk   (clk),
      .aclr  (aclr),
      .sclr  (edge_clr),
      .en    (run & en_w),
      .count (w_addr)
   );

   // Offset wraps on its own at the final beat, so only sclr clears it early.
   pe_wrap_counter #(.WIDTH(OFF_W), .LIMIT(I_SPAN)) u_i_off_cnt (
      .clk   (clk),
      .aclr  (aclr),
      .sclr  (sclr),
      .en    (run & en_i),
      .count (offset)
   );

   pe_wrap_counter #(.WIDTH(O_AW), .LIMIT(O_GROUP)) u_o_in_cnt (
      .clk   (clk),
      .aclr  (aclr),
      .sclr  (edge_clr),
      .en    (run & en_o_in),
      .count (o_in_addr)
   );

   pe_wrap_counter #(.WIDTH(O_AW), .LIMIT(O_GROUP)) u_o_out_cnt (
      .clk   (clk),
      .aclr  (aclr),
      .sclr  (edge_clr),
      .en    (run & en_o_out),
      .count (o_out_addr)
   );

   // Consecutive blocks overlap by I_SPAN-I_STRIDE input PEs.
   assign i_addr = I_AW'(32'(i_block) * I_STRIDE + 32'(offset));

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err_en  <= 1'b0;
         i_block <= '0;
      end else if (sclr) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err_en  <= 1'b0;
         i_block <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (any_en) begin
                  err_en <= 1'b1;
               end
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (en_i && off_max) begin
                  if (blk_max) begin
                     i_block <= '0;
                     state   <= IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     i_block <= i_block + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_edge_sequencer.sv
// tb/tb_pe_edge_sequencer.sv - scoreboard bench for pe_edge_sequencer
module tb_pe_edge_sequencer;

   localparam int W_GROUP  = 4;
   localparam int O_GROUP  = 4;
   localparam int I_SPAN   = 7;
   localparam int I_STRIDE = 3;
   localparam int I_BLOCKS = 4;

   logic       clk;
   logic       aclr;
   logic       sclr;
   logic       start;
   logic       en_w;
   logic       en_i;
   logic       en_o_in;
   logic       en_o_out;
   logic [1:0] w_addr;
   logic [1:0] o_in_addr;
   logic [1:0] o_out_addr;
   logic [3:0] i_addr;
   logic [1:0] i_block;
   logic       busy;
   logic       done;
   logic       err_en;

   typedef struct {
      int w;
      int oi;
      int oo;
      int ia;
      int blk;
      int busy;
      int done;
      int err;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;
   int done_seen = 0;

   int m_run, m_w, m_oi, m_oo, m_off, m_blk, m_done, m_err;

   pe_edge_sequencer dut (
      .clk        (clk),
      .aclr       (aclr),
      .sclr       (sclr),
      .start      (start),
      .en_w       (en_w),
      .en_i       (en_i),
      .en_o_in    (en_o_in),
      .en_o_out   (en_o_out),
      .w_addr     (w_addr),
      .o_in_addr  (o_in_addr),
      .o_out_addr (o_out_addr),
      .i_addr     (i_addr),
      .i_block    (i_block),
      .busy       (busy),
      .done       (done),
      .err_en     (err_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_w = 0; m_oi = 0; m_oo = 0;
      m_off = 0; m_blk = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_step(input logic s_start, input logic s_sclr, input logic e_w,
                             input logic e_i, input logic e_oi, input logic e_oo);
      if (s_sclr) begin
         model_reset();
      end else begin
         m_done = 0;
         if (m_run == 0) begin
            if (e_w || e_i || e_oi || e_oo) m_err = 1;
            if (s_start) m_run = 1;
         end else begin
            if (e_w)  m_w  = (m_w + 1) % W_GROUP;
            if (e_oi) m_oi = (m_oi + 1) % O_GROUP;
            if (e_oo) m_oo = (m_oo + 1) % O_GROUP;
            if (e_i) begin
               if (m_off == I_SPAN - 1) begin
                  m_off = 0;
                  if (m_blk == I_BLOCKS - 1) begin
                     m_blk = 0; m_w = 0; m_oi = 0; m_oo = 0;
                     m_run = 0; m_done = 1;
                  end else begin
                     m_blk++;
                  end
               end else begin
                  m_off++;
               end
            end
         end
      end
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.w = m_w; e.oi = m_oi; e.oo = m_oo;
      e.ia = (m_blk * I_STRIDE + m_off) % 16;
      e.blk = m_blk; e.busy = m_run; e.done = m_done; e.err = m_err;
      return e;
   endfunction

   task automatic check_front();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk("w_addr",     32'(w_addr),     32'(e.w));
         chk("o_in_addr",  32'(o_in_addr),  32'(e.oi));
         chk("o_out_addr", 32'(o_out_addr), 32'(e.oo));
         chk("i_addr",     32'(i_addr),     32'(e.ia));
         chk("i_block",    32'(i_block),    32'(e.blk));
         chk("busy",       32'(busy),       32'(e.busy));
         chk("done",       32'(done),       32'(e.done));
         chk("err_en",     32'(err_en),     32'(e.err));
      end
      if (done === 1'b1) done_seen++;
   endtask

   task automatic step(input logic s_start, input logic s_sclr, input logic e_w,
                       input logic e_i, input logic e_oi, input logic e_oo);
      @(negedge clk);
      start = s_start; sclr = s_sclr;
      en_w = e_w; en_i = e_i; en_o_in = e_oi; en_o_out = e_oo;
      model_step(s_start, s_sclr, e_w, e_i, e_oi, e_oo);
      sb.push_back(snapshot());
      @(posedge clk);
      #1;
      check_front();
      start = 0; sclr = 0; en_w = 0; en_i = 0; en_o_in = 0; en_o_out = 0;
   endtask

   int wexp[5] = '{1, 2, 3, 0, 1};

   initial begin
      aclr = 1'b1; sclr = 0; start = 0;
      en_w = 0; en_i = 0; en_o_in = 0; en_o_out = 0;
      model_reset();
      #12;
      sb.push_back(snapshot());
      check_front();
      @(negedge clk);
      aclr = 1'b0;

      // sclr wins over start
      step(1, 1, 0, 0, 0, 0);
      chk("sclr_start_busy", 32'(busy), 32'd0);

      // enables in IDLE are ignored but flagged
      step(0, 0, 0, 1, 0, 0);
      chk("idle_i_addr", 32'(i_addr), 32'd0);
      chk("idle_err_en", 32'(err_en), 32'd1);
      step(0, 1, 0, 0, 0, 0);
      chk("sclr_err_clr", 32'(err_en), 32'd0);

      // first block walks 0..6, then next block starts at stride
      step(1, 0, 0, 0, 0, 0);
      chk("run_i_addr0", 32'(i_addr), 32'd0);
      for (int k = 0; k < 7; k++) begin
         step(0, 0, 0, 1, 0, 0);
         if (k < 6) chk("blk0_i_addr", 32'(i_addr), 32'(k + 1));
      end
      chk("blk1_i_block", 32'(i_block), 32'd1);
      chk("blk1_i_addr",  32'(i_addr),  32'd3);

      // complete the pass: 28 beats total
      done_seen = 0;
      for (int k = 7; k < 28; k++) begin
         step(0, 0, 0, 1, 0, 0);
         if (k == 13) chk("blk2_i_block", 32'(i_block), 32'd2);
         if (k == 20) chk("blk3_i_block", 32'(i_block), 32'd3);
      end
      chk("end_i_block", 32'(i_block), 32'd0);
      chk("end_busy",    32'(busy),    32'd0);
      chk("end_done",    32'(done),    32'd1);
      step(0, 0, 0, 0, 0, 0);
      chk("done_pulses", 32'(done_seen), 32'd1);

      // en_w held for five cycles
      step(1, 0, 0, 0, 0, 0);
      chk("w_start", 32'(w_addr), 32'd0);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 1, 0, 0, 0);
         chk("w_seq", 32'(w_addr), 32'(wexp[k]));
      end

      // mixed enables, all four together at times
      for (int k = 0; k < 60; k++) begin
         step(($urandom_range(0, 3) == 0), 1'b0,
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      // aclr mid-pass at i_block=2, offset=4
      step(0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 18; k++) step(0, 0, 0, 1, 0, 0);
      chk("pre_aclr_i_block", 32'(i_block), 32'd2);
      chk("pre_aclr_i_addr",  32'(i_addr),  32'd10);
      @(negedge clk);
      #2 aclr = 1'b1;
      #1;
      model_reset();
      sb.push_back(snapshot());
      check_front();
      @(negedge clk);
      aclr = 1'b0;
      step(0, 0, 0, 1, 0, 0);
      chk("post_aclr_i_addr", 32'(i_addr), 32'd0);
      chk("post_aclr_busy",   32'(busy),   32'd0);
      step(0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("restart_i_addr", 32'(i_addr), 32'd1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pe_edge_sequencer.md
PE_EDGE_SEQUENCER -- requirements
Module: pe_edge_sequencer

Interface
REQ-001 SHALL have parameter W_GROUP, default 4: weight-edge PE count.
REQ-002 SHALL have parameter O_GROUP, default 4: output-edge PE count.
REQ-003 SHALL have parameter I_SPAN, default 7 (W_GROUP+O_GROUP-1): input beats per block.
REQ-004 SHALL have parameter I_STRIDE, default 3 (O_GROUP-1): input-address advance per block.
REQ-005 SHALL have parameter I_BLOCKS, default 4: blocks per pass.
REQ-006 SHALL have parameters W_AW 2, O_AW 2, I_AW 4, BC_W 2: address and block-counter widths.
REQ-007 SHALL have port clk, input, 1: clock, rising edge.
REQ-008 SHALL have port aclr, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port sclr, input, 1: synchronous clear, active-high.
REQ-010 SHALL have port start, input, 1: begin pass.
REQ-011 SHALL have ports en_w, en_i, en_o_in, en_o_out, input, 1 each: per-edge beat enables.
REQ-012 SHALL have ports w_addr (W_AW), o_in_addr (O_AW), o_out_addr (O_AW), output: edge PE addresses.
REQ-013 SHALL have port i_addr, output, I_AW: input-edge PE address.
REQ-014 SHALL have port i_block, output, BC_W: current block index.
REQ-015 SHALL have ports busy (1-bit level), done (1-cycle pulse) and err_en (1-bit sticky), all outputs.

Function
REQ-016 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start; start in RUN ignored.
REQ-017 SHALL hold busy=1 exactly while in RUN.
REQ-018 SHALL, in RUN, advance w_addr by 1 on en_w and wrap to 0 after W_GROUP-1.
REQ-019 SHALL advance o_in_addr on en_o_in and o_out_addr on en_o_out, each wrapping to 0 after O_GROUP-1, independently.
REQ-020 SHALL keep an input offset counter 0..I_SPAN-1, advanced on en_i.
REQ-021 SHALL drive i_addr = i_block*I_STRIDE + offset, combinationally, truncated to I_AW.
REQ-022 SHALL, on en_i with offset=I_SPAN-1, clear offset and increment i_block.
REQ-023 SHALL, on en_i with offset=I_SPAN-1 and i_block=I_BLOCKS-1, clear i_block, clear w/o_in/o_out counters, go to IDLE and pulse done the following cycle.
REQ-024 SHALL accept all four enables in the same cycle, each counter updating independently.
REQ-025 SHALL ignore enables in IDLE (no counter change) and set err_en, held until sclr or aclr.
REQ-026 SHALL never let i_block reach I_BLOCKS, nor any address exceed its group maximum.
REQ-027 SHALL, on sclr, clear all counters, done and err_en, and enter IDLE, with priority over start and enables.
REQ-028 SHALL produce zero-latency addresses: each address reflects all enables accepted up to the previous edge.

Reset
REQ-029 SHALL, on aclr, immediately force IDLE, all addresses 0, i_block 0, busy 0, done 0, err_en 0.
REQ-030 SHALL, when aclr deasserts mid-pass, resume in IDLE and require a fresh start.

Structure
REQ-031 SHALL place the FSM state enum and default group/width constants in the shared PE package.
REQ-032 SHALL instantiate one sub-module, pe_wrap_counter (parametric width and wrap limit, EN, sclr), four times (w, i offset, o_in, o_out).
REQ-033 SHALL keep the i_block counter and i_addr arithmetic in the top level.

Verification
REQ-034 SHALL cover: start, then 7 en_i beats -> i_addr 0..6, then i_block=1 and i_addr=3 after the 7th beat.
REQ-035 SHALL cover: start, then 28 en_i beats -> i_block sequence 0,1,2,3,0; busy falls and done pulses once, the cycle after beat 28.
REQ-036 SHALL cover: en_w held for 5 cycles in RUN -> w_addr 0,1,2,3,0,1.
REQ-037 SHALL cover: en_i in IDLE -> i_addr stays 0 and err_en=1; sclr -> err_en=0.
REQ-038 SHALL cover: aclr pulse at i_block=2, offset=4 -> all outputs 0 immediately, FSM IDLE, en_i ignored until start.
REQ-039 SHALL cover: sclr and start in the same cycle -> FSM stays IDLE, busy=0.
